// File: rtl/demux_8_deser.sv
// ---------------------------------------------------------------------------
// demux_8_deser
//
// Serial-to-parallel deserializer. Each accepted serial bit is steered by a
// 3-bit slot index through an 8-way one-hot decode into one position of an
// internal collect register. The 8th bit completes a byte, which is handed to
// a single-entry registered output stage with a valid/ready handshake.
//
// Configuration macro:
//   DESER_MSB_FIRST_EN  defined   -> first bit lands in byte_out[7]
//                       undefined -> first bit lands in byte_out[0]
//
// Parameters:
//   RST_BYTE    value loaded into byte_out while rst is asserted
//
// Ports:
//   clk         single clock, rising edge
//   rst         asynchronous active-high reset
//   clr         synchronous clear of partial byte, bit counter and overrun
//   bit_in      serial data bit
//   bit_valid   bit_in is valid this cycle (always accepted)
//   out_ready   consumer accepts byte_out this cycle
//   byte_out    assembled byte (registered)
//   byte_valid  byte_out holds an unconsumed byte
//   bit_cnt     index of the next bit slot to be written
//   overrun     sticky: a completed byte was dropped
// ---------------------------------------------------------------------------
module demux_8_deser #(
    parameter logic [7:0] RST_BYTE = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       bit_in,
    input  logic       bit_valid,
    input  logic       out_ready,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic [2:0] bit_cnt,
    output logic       overrun
);

    typedef enum logic {
        IDLE,
        COLLECT
    } state_t;

    state_t     state;
    state_t     state_next;

    logic [7:0] collector;
    logic [7:0] collector_base;
    logic [7:0] collector_written;
    logic [7:0] slot_dec;
    logic [2:0] write_idx;
    logic [2:0] slot_idx;
    logic       last_bit;
    logic       handshake;
    logic       load_byte;
    logic       drop_byte;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic. A clear coinciding with a bit still leaves one
    // bit held, so the FSM stays (or goes) in COLLECT in that case.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bit_valid) begin
                    state_next = COLLECT;
                end
            end
            COLLECT: begin
                if (clr) begin
                    state_next = bit_valid ? COLLECT : IDLE;
                end else if (bit_valid && (bit_cnt == 3'd7)) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // FSM output logic: the slot index this cycle's bit is written to (clear
    // takes priority, so a bit arriving with clr goes to slot 0), and whether
    // this bit completes the byte.
    always_comb begin
        write_idx = 3'd0;
        last_bit  = 1'b0;
        if ((state == COLLECT) && !clr) begin
            write_idx = bit_cnt;
            last_bit  = bit_valid && (bit_cnt == 3'd7);
        end
    end

    // Bit-order mapping from slot index to register position
`ifdef DESER_MSB_FIRST_EN
    assign slot_idx = 3'd7 - write_idx;
`else
    assign slot_idx = write_idx;
`endif

    // 8-way decode and the collect register contents including this bit
    assign slot_dec          = 8'b0000_0001 << slot_idx;
    assign collector_base    = clr ? 8'h00 : collector;
    assign collector_written = bit_valid
                             ? ((collector_base & ~slot_dec) | (bit_in ? slot_dec : 8'h00))
                             : collector_base;

    // Output stage decisions: a completed byte loads when the stage is empty
    // or being emptied this cycle, otherwise it is dropped.
    assign handshake = byte_valid && out_ready;
    assign load_byte = last_bit && (!byte_valid || out_ready);
    assign drop_byte = last_bit && byte_valid && !out_ready;

    // Collector and bit counter; the collector restarts empty once a byte
    // completes, whether it was kept or dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            collector <= 8'h00;
            bit_cnt   <= 3'd0;
        end else begin
            collector <= last_bit ? 8'h00 : collector_written;
            if (clr) begin
                bit_cnt <= {2'b00, bit_valid};
            end else begin
                bit_cnt <= bit_cnt + {2'b00, bit_valid};
            end
        end
    end

    // Registered output byte and valid flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_out   <= RST_BYTE;
            byte_valid <= 1'b0;
        end else begin
            if (load_byte) begin
                byte_out   <= collector_written;
                byte_valid <= 1'b1;
            end else if (handshake) begin
                byte_valid <= 1'b0;
            end
        end
    end

    // Sticky overrun flag, cleared only by clr or rst
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun <= 1'b0;
        end else begin
            if (clr) begin
                overrun <= 1'b0;
            end else if (drop_byte) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_demux_8_deser.sv
// ---------------------------------------------------------------------------
// tb_demux_8_deser
//
// Self-checking bench for demux_8_deser: a table of directed vectors, a few
// hand-written multi-cycle sequences (async reset, clr with a bit, idle hold)
// and a randomized run compared against a queue-based behavioural model.
// Honours DESER_MSB_FIRST_EN for bit-order dependent expectations.
// ---------------------------------------------------------------------------
module tb_demux_8_deser;

    localparam logic [7:0] RST_VAL = 8'hC3;

`ifdef DESER_MSB_FIRST_EN
    localparam logic [7:0] E28     = 8'hA1;
    localparam logic [7:0] E_SLOT0 = 8'h80;
`else
    localparam logic [7:0] E28     = 8'h85;
    localparam logic [7:0] E_SLOT0 = 8'h01;
`endif

    logic       clk;
    logic       rst;
    logic       clr;
    logic       bit_in;
    logic       bit_valid;
    logic       out_ready;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic [2:0] bit_cnt;
    logic       overrun;

    int checks;
    int failures;

    // Behavioural model: received bits in arrival order plus the output stage
    bit         mq[$];
    logic [7:0] m_byte;
    logic       m_valid;
    logic       m_ovr;

    typedef struct {
        logic       clr;
        logic       bit_in;
        logic       bit_valid;
        logic       out_ready;
        logic [7:0] exp_byte;
        logic       exp_valid;
        logic [2:0] exp_cnt;
        logic       exp_ovr;
    } vec_t;

    vec_t vecs[$];

    demux_8_deser #(.RST_BYTE(RST_VAL)) dut (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .out_ready  (out_ready),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .bit_cnt    (bit_cnt),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Serial bit i of byte b in the configured transmission order
    function automatic logic bit_of(input logic [7:0] b, input int i);
        logic [7:0] v;
        v = b;
`ifdef DESER_MSB_FIRST_EN
        return v[7 - i];
`else
        return v[i];
`endif
    endfunction

    // Assemble a byte from 8 bits in arrival order
    function automatic logic [7:0] build_byte(input bit q[$]);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < 8; i++) begin
`ifdef DESER_MSB_FIRST_EN
            r[7 - i] = q[i];
`else
            r[i] = q[i];
`endif
        end
        return r;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_byte  = RST_VAL;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
    endtask

    // One clock of the model using the inputs present at the edge
    task automatic model_update();
        logic       hs;
        logic [7:0] nb;
        hs = m_valid && out_ready;
        if (clr) begin
            mq.delete();
            m_ovr = 1'b0;
        end
        if (bit_valid) mq.push_back(bit_in);
        if (mq.size() == 8) begin
            nb = build_byte(mq);
            mq.delete();
            if (!m_valid || out_ready) begin
                m_byte  = nb;
                m_valid = 1'b1;
            end else begin
                m_ovr = 1'b1;
            end
        end else if (hs) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic c, input logic b, input logic v, input logic r);
        clr       = c;
        bit_in    = b;
        bit_valid = v;
        out_ready = r;
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] eb, input logic ev,
                               input logic [2:0] ec, input logic eo);
        check({tag, ".byte_out"},   byte_out,         eb);
        check({tag, ".byte_valid"}, 8'(byte_valid),   8'(ev));
        check({tag, ".bit_cnt"},    8'(bit_cnt),      8'(ec));
        check({tag, ".overrun"},    8'(overrun),      8'(eo));
    endtask

    task automatic add_vec(input logic c, input logic b, input logic v, input logic r,
                           input logic [7:0] eb, input logic ev, input logic [2:0] ec,
                           input logic eo);
        vec_t t;
        t.clr = c; t.bit_in = b; t.bit_valid = v; t.out_ready = r;
        t.exp_byte = eb; t.exp_valid = ev; t.exp_cnt = ec; t.exp_ovr = eo;
        vecs.push_back(t);
    endtask

    // Eight vectors sending byte b; expectations for the first seven bits and the 8th
    task automatic add_byte(input logic [7:0] b, input logic rdy7, input logic rdy8,
                            input logic [7:0] mid_b, input logic mid_v, input logic mid_o,
                            input logic [7:0] fin_b, input logic fin_v, input logic fin_o);
        for (int i = 0; i < 7; i++) begin
            add_vec(1'b0, bit_of(b, i), 1'b1, rdy7, mid_b, mid_v, 3'(i + 1), mid_o);
        end
        add_vec(1'b0, bit_of(b, 7), 1'b1, rdy8, fin_b, fin_v, 3'd0, fin_o);
    endtask

    initial begin
        logic [7:0] pat;
        checks    = 0;
        failures  = 0;
        rst       = 1'b0;
        clr       = 1'b0;
        bit_in    = 1'b0;
        bit_valid = 1'b0;
        out_ready = 1'b0;
        model_reset();

        // Reset is asynchronous and blocks bit acceptance while held
        #1 rst = 1'b1;
        #1 checkOutput("reset_async", RST_VAL, 1'b0, 3'd0, 1'b0);
        bit_in    = 1'b1;
        bit_valid = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 checkOutput("reset_held", RST_VAL, 1'b0, 3'd0, 1'b0);
        rst       = 1'b0;
        bit_valid = 1'b0;

        // Directed vector table
        pat = 8'hA1;
        for (int i = 0; i < 7; i++) begin
            add_vec(1'b0, pat[7 - i], 1'b1, 1'b1, RST_VAL, 1'b0, 3'(i + 1), 1'b0);
        end
        add_vec(1'b0, pat[0], 1'b1, 1'b1, E28, 1'b1, 3'd0, 1'b0);
        add_vec(1'b0, 1'b0, 1'b0, 1'b1, E28, 1'b0, 3'd0, 1'b0);
        add_byte(8'h3C, 1'b0, 1'b0, E28,   1'b0, 1'b0, 8'h3C, 1'b1, 1'b0);
        add_byte(8'hFF, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b1);
        add_vec(1'b1, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b1, 3'd0, 1'b0);
        add_vec(1'b0, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 3'd0, 1'b0);
        add_byte(8'h12, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 8'h12, 1'b1, 1'b0);
        add_byte(8'h5A, 1'b0, 1'b1, 8'h12, 1'b1, 1'b0, 8'h5A, 1'b1, 1'b0);
        add_vec(1'b0, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b0, 3'd0, 1'b0);

        foreach (vecs[k]) begin
            applyStimulus(vecs[k].clr, vecs[k].bit_in, vecs[k].bit_valid, vecs[k].out_ready);
            checkOutput($sformatf("vec%0d", k), vecs[k].exp_byte, vecs[k].exp_valid,
                        vecs[k].exp_cnt, vecs[k].exp_ovr);
        end

        // Three bits, then idle cycles must hold the count
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        check("three_bits.bit_cnt", 8'(bit_cnt), 8'd3);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        check("idle_hold.bit_cnt", 8'(bit_cnt), 8'd3);

        // clr together with a 1 bit: that bit becomes slot 0
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
        check("clr_bit.bit_cnt", 8'(bit_cnt), 8'd1);
        for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("clr_bit_byte", E_SLOT0, 1'b1, 3'd0, 1'b0);

        // Reset pulse mid-byte between clock edges
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        check("five_bits.bit_cnt", 8'(bit_cnt), 8'd5);
        #1 rst = 1'b1;
        #2 checkOutput("rst_mid", RST_VAL, 1'b0, 3'd0, 1'b0);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, bit_of(8'hAA, i), 1'b1, 1'b1);
        checkOutput("after_rst", 8'hAA, 1'b1, 3'd0, 1'b0);

        // Randomized run against the behavioural model
        for (int n = 0; n < 400; n++) begin
            applyStimulus(($urandom_range(0, 15) == 0), 1'($urandom),
                          ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0));
            check("rand.byte_out",   byte_out,        m_byte);
            check("rand.byte_valid", 8'(byte_valid),  8'(m_valid));
            check("rand.bit_cnt",    8'(bit_cnt),     8'(mq.size()));
            check("rand.overrun",    8'(overrun),     8'(m_ovr));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
